// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: access-size codes, FSM states and
// small helpers used by both the stage controller and the lane steering.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

  // Bits needed for a counter that must be able to hold the value `cycles`.
  function automatic int timeout_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // Halfwords need an even address; words (and any unknown size) need a
  // word-aligned address; bytes can never be misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    case (funct3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return offset[0];
      default:     return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data
// for the access being issued, and extraction plus sign/zero extension of the
// returned read word for the access in flight.
module mem_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Byte enables and lane-replicated store data for the issuing access.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    be    = 4'b0000;
    wdata = 32'h0;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Select the addressed byte/half of the read word and extend it.
  always_comb begin
    ld_byte   = 8'h0;
    ld_half   = ld_offset[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (ld_offset)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    case (ld_funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_data = {24'h0, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_data = {16'h0, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory pipeline stage: accepts a load/store from execute, runs it over the
// req/gnt/rvalid data bus, stalls the pipeline until it completes, and reports
// misalignment or bus timeout instead of issuing or hanging.
module mem_access
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_write_data,
  output logic        m_stall,
  output logic        m_done,
  output logic [31:0] m_load_data,
  output logic        m_misalign,
  output logic        m_bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = timeout_width(TIMEOUT_CYCLES);

  mem_state_e  state;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_inc;
  logic        tmo_hit;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        accept;
  logic        acc_we;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  // A simultaneous read and write request is treated as a load.
  assign accept  = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign acc_we  = ex_mem_wr & ~ex_mem_rd;
  assign tmo_inc = tmo_cnt + 1'b1;
  assign tmo_hit = tmo_inc >= CW'(TIMEOUT_CYCLES);

  // Freeze upstream while an access is being accepted or is on the bus; the
  // DONE cycle lets the pipeline advance.
  assign m_stall = ((state == S_IDLE) && accept) || (state == S_REQ) || (state == S_RSP);

  // Store lanes come from the live execute operands (registered on accept);
  // load extraction uses the captured size/offset of the access in flight.
  mem_align u_align (
    .funct3     (ex_funct3),
    .offset     (ex_alu_out[1:0]),
    .store_data (ex_write_data),
    .be         (al_be),
    .wdata      (al_wdata),
    .ld_funct3  (f3_q),
    .ld_offset  (off_q),
    .rdata      (dmem_rdata),
    .load_data  (al_load)
  );

  // Access FSM with registered bus and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      m_done      <= 1'b0;
      m_load_data <= 32'h0;
      m_misalign  <= 1'b0;
      m_bus_err   <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_be     <= 4'b0000;
      dmem_wdata  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            f3_q    <= ex_funct3;
            off_q   <= ex_alu_out[1:0];
            tmo_cnt <= '0;
            if (is_misaligned(ex_funct3, ex_alu_out[1:0])) begin
              state      <= S_DONE;
              m_done     <= 1'b1;
              m_misalign <= 1'b1;
            end else begin
              state      <= S_REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= acc_we;
              dmem_addr  <= {ex_alu_out[31:2], 2'b00};
              dmem_be    <= al_be;
              dmem_wdata <= acc_we ? al_wdata : 32'h0;
            end
          end
        end
        S_REQ: begin
          tmo_cnt <= tmo_inc;
          if (dmem_gnt || tmo_hit) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0;
            if (dmem_gnt && !dmem_we) begin
              state <= S_RSP;
            end else begin
              state     <= S_DONE;
              m_done    <= 1'b1;
              m_bus_err <= !dmem_gnt;
            end
          end
        end
        S_RSP: begin
          tmo_cnt <= tmo_inc;
          if (dmem_rvalid) begin
            state       <= S_DONE;
            m_done      <= 1'b1;
            m_load_data <= al_load;
          end else if (tmo_hit) begin
            state     <= S_DONE;
            m_done    <= 1'b1;
            m_bus_err <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          m_done      <= 1'b0;
          m_misalign  <= 1'b0;
          m_bus_err   <= 1'b0;
          m_load_data <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a scoreboard of expected completions is
// filled when an access is driven and drained when the DUT reports m_done.
module tb_mem_access;

  localparam int TMO = 8;
  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_mem_rd = 1'b0, ex_mem_wr = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_alu_out = 32'h0, ex_write_data = 32'h0;
  logic        m_stall, m_done, m_misalign, m_bus_err;
  logic [31:0] m_load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_funct3(ex_funct3), .ex_alu_out(ex_alu_out), .ex_write_data(ex_write_data),
    .m_stall(m_stall), .m_done(m_done), .m_load_data(m_load_data),
    .m_misalign(m_misalign), .m_bus_err(m_bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  // ---- reference model ----
  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == B || f3 == BU) return 1'b0;
    if (f3 == H || f3 == HU) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == B || f3 == BU) return 4'(1 << a[1:0]);
    if (f3 == H || f3 == HU) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == B || f3 == BU) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f3 == H || f3 == HU) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] r);
    logic [31:0] sb_w, sh_w;
    sb_w = r >> (8 * a[1:0]);
    sh_w = r >> (16 * a[1]);
    case (f3)
      B:  return (sb_w & 32'hFF) | (sb_w[7] ? 32'hFFFF_FF00 : 32'h0);
      BU: return sb_w & 32'hFF;
      H:  return (sh_w & 32'hFFFF) | (sh_w[15] ? 32'hFFFF_0000 : 32'h0);
      HU: return sh_w & 32'hFFFF;
      default: return r;
    endcase
  endfunction

  // Drive one access and follow it to completion. gnt_dly/rsp_dly < 0 means
  // the bus never answers that phase.
  task automatic do_access(input string nm, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int gnt_dly,
                           input int rsp_dly, input logic [31:0] rdata,
                           input bit tmo);
    exp_t e, got;
    logic we, mis;
    logic [68:0] bus_exp;
    int req_cyc, gnt_cyc;
    bit done_seen;
    we  = wr & ~rd;
    mis = m_mis(f3, a);
    e.mis  = mis;
    e.err  = tmo && !mis;
    e.data = (mis || tmo || we) ? 32'h0 : m_ld(f3, a, rdata);
    e.lat  = mis ? 1 : tmo ? TMO + 1 : we ? gnt_dly + 2 : gnt_dly + rsp_dly + 3;
    bus_exp = {{a[31:2], 2'b00}, m_be(f3, a), we, (we ? m_wd(f3, wd) : 32'h0)};
    sb.push_back(e);
    ex_valid = 1'b1; ex_mem_rd = rd; ex_mem_wr = wr;
    ex_funct3 = f3; ex_alu_out = a; ex_write_data = wd;
    #1;
    total++;
    if (m_stall !== 1'b1) begin
      bad++; $display("FAIL %s accept_stall got=%b want=1", nm, m_stall);
    end
    req_cyc = 0; gnt_cyc = 0; done_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dmem_req === 1'b1) begin
        req_cyc++;
        total++;
        if ({dmem_addr, dmem_be, dmem_we, dmem_wdata} !== bus_exp) begin
          bad++;
          $display("FAIL %s bus_fields got=%h/%b/%b/%h want=%h/%b/%b/%h", nm,
                   dmem_addr, dmem_be, dmem_we, dmem_wdata,
                   bus_exp[68:37], bus_exp[36:33], bus_exp[32], bus_exp[31:0]);
        end
      end
      if (m_done === 1'b1) begin
        done_seen = 1;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL %s unexpected_done got=1 want=0", nm);
        end else begin
          got = sb.pop_front();
          if ({m_load_data, m_misalign, m_bus_err} !== {got.data, got.mis, got.err} ||
              k != got.lat || m_stall !== 1'b0 || dmem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s done got=data %h mis %b err %b lat %0d stall %b req %b want=data %h mis %b err %b lat %0d stall 0 req 0",
                     nm, m_load_data, m_misalign, m_bus_err, k, m_stall, dmem_req,
                     got.data, got.mis, got.err, got.lat);
          end
        end
        if (mis) begin
          total++;
          if (req_cyc != 0) begin
            bad++; $display("FAIL %s misalign_no_req got=%0d want=0", nm, req_cyc);
          end
        end
        break;
      end
      total++;
      if (m_stall !== 1'b1) begin
        bad++; $display("FAIL %s busy_stall cycle %0d got=%b want=1", nm, k, m_stall);
      end
      dmem_gnt = (dmem_req === 1'b1) && gnt_dly >= 0 && req_cyc == gnt_dly + 1;
      if (dmem_gnt) gnt_cyc = k;
      dmem_rvalid = gnt_cyc > 0 && !we && rsp_dly >= 0 && (k - gnt_cyc) == rsp_dly + 1;
      dmem_rdata  = dmem_rvalid ? rdata : $urandom;
    end
    ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    if (!done_seen) begin
      total++; bad++;
      $display("FAIL %s done_timeout got=none want=m_done", nm);
      sb.delete();
    end
    @(negedge clk);
    total++;
    if (m_done !== 1'b0 || m_stall !== 1'b0 || dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done got=done %b stall %b req %b want=0 0 0", nm, m_done, m_stall, dmem_req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({m_stall, m_done, m_load_data, m_misalign, m_bus_err, dmem_req, dmem_we,
         dmem_addr, dmem_be, dmem_wdata} !== '0) begin
      bad++; $display("FAIL reset_outputs got=nonzero want=0");
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_access("sb_103", 0, 1, B,  32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0, 0);
    do_access("lb_102", 1, 0, B,  32'h0000_0102, 32'h0, 0, 0, 32'h0080_0000, 0);
    do_access("lbu_102", 1, 0, BU, 32'h0000_0102, 32'h0, 0, 0, 32'h0080_0000, 0);
    do_access("lh_101_mis", 1, 0, H, 32'h0000_0101, 32'h0, 0, 0, 32'h0, 0);
    do_access("lw_slow", 1, 0, W, 32'h0000_0040, 32'h0, 4, 1, 32'hDEAD_BEEF, 0);
    do_access("sh_102", 0, 1, H,  32'h0000_0102, 32'h1234_5678, 1, 0, 32'h0, 0);
    do_access("sw_200", 0, 1, W,  32'h0000_0200, 32'hCAFE_F00D, 2, 0, 32'h0, 0);
    do_access("sw_mis", 0, 1, W,  32'h0000_0202, 32'h1, 0, 0, 32'h0, 0);
    do_access("lh_100", 1, 0, H,  32'h0000_0100, 32'h0, 0, 0, 32'h7777_8001, 0);
    do_access("lhu_102", 1, 0, HU, 32'h0000_0102, 32'h0, 0, 2, 32'h8001_0000, 0);
    do_access("rdwr_load", 1, 1, BU, 32'h0000_0301, 32'h55, 0, 0, 32'h0000_9A00, 0);
    do_access("undef_f3_mis", 1, 0, 3'b011, 32'h0000_0001, 32'h0, 0, 0, 32'h0, 0);
  endtask

  task automatic test_timeout();
    do_access("tmo_req", 1, 0, W, 32'h0000_0400, 32'h0, -1, 0, 32'h0, 1);
    do_access("tmo_rsp", 1, 0, W, 32'h0000_0404, 32'h0, 0, -1, 32'h0, 1);
    // Late bus responses while idle must be ignored.
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (m_done !== 1'b0 || dmem_req !== 1'b0 || m_stall !== 1'b0) begin
        bad++; $display("FAIL late_resp_idle got=done %b req %b stall %b want=0 0 0", m_done, dmem_req, m_stall);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_funct3 = W; ex_alu_out = 32'h0000_0500;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    total++;
    if (m_stall !== 1'b1 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL rsp_state got=stall %b req %b want=1 0", m_stall, dmem_req);
    end
    ex_valid = 1'b0; ex_mem_rd = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_stall, m_done, m_load_data, m_misalign, m_bus_err, dmem_req, dmem_we,
         dmem_addr, dmem_be, dmem_wdata} !== '0) begin
      bad++; $display("FAIL reset_mid_rsp got=nonzero want=0");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    repeat (2) begin
      total++;
      if (m_done !== 1'b0 || m_load_data !== 32'h0) begin
        bad++; $display("FAIL stray_rvalid got=done %b data %h want=0 0", m_done, m_load_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] sizes [5] = '{B, H, W, BU, HU};
    for (int i = 0; i < 20; i++) begin
      logic [2:0] f3;
      logic [31:0] a;
      logic rd;
      f3 = sizes[$urandom_range(0, 4)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (f3 == W) ? 2'b00 : (f3 == H || f3 == HU) ? {a[1], 1'b0} : a[1:0];
      rd = 1'($urandom_range(0, 1));
      do_access("rand", rd, !rd, f3, a, $urandom, $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
